id_operand_fetch: RTL and testbench
===================================

Name: id_operand_fetch

Overview:
- Decode/operand-fetch stage sitting directly upstream of the EXP5 register file (Regs) consumers.
- Accepts a 32-bit MIPS instruction with a valid/ready handshake and drives the Regs read addresses.
- Captures rdata_A/rdata_B, with write-back bypass, into a one-entry output register for the execute stage.
- Also produces the decoded immediate, destination register, opcode and funct.

Parameters:
- DW, 32, datapath width (operands, immediate, PC)
- AW, 5, register address width

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-low reset (rst=0 at a rising edge resets)
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept this cycle
- inst  in  32  instruction word
- pc_in  in  DW  PC of inst
- R_addr_A  out  AW  to Regs, = inst[25:21] (rs), combinational
- R_addr_B  out  AW  to Regs, = inst[20:16] (rt), combinational
- rdata_A  in  DW  from Regs, combinational read of R_addr_A
- rdata_B  in  DW  from Regs, combinational read of R_addr_B
- wb_en  in  1  write-back enable, same signal as Regs L_S
- wb_addr  in  AW  write-back address, same as Regs Wt_addr
- wb_data  in  DW  write-back data, same as Regs Wt_data
- out_valid  out  1  output register holds an instruction
- out_ready  in  1  downstream accepts
- op_a  out  DW  rs operand
- op_b  out  DW  rt operand
- imm  out  DW  extended immediate
- dst  out  AW  destination register
- opcode  out  6  inst[31:26]
- funct  out  6  inst[5:0]
- src_a  out  AW  captured rs address
- src_b  out  AW  captured rt address
- pc_out  out  DW  captured PC

Behaviour:
- Reset (rst=0 at clk edge): state EMPTY, out_valid=0, and all registered outputs (op_a, op_b, imm, dst, opcode, funct, src_a, src_b, pc_out) = 0. Reset overrides any same-cycle handshake. in_ready during reset is don't-care; it is 1 on the first cycle after reset.
- States:
  - EMPTY (out_valid=0).
  - FULL (out_valid=1).
- Handshake:
  - in_ready = !out_valid | out_ready.
  - accept = in_valid & in_ready.
  - drain = out_valid & out_ready.
- Transitions:
  - EMPTY + accept -> FULL.
  - FULL + drain + !accept -> EMPTY.
  - FULL + drain + accept -> FULL with the new instruction (back-to-back, full throughput).
  - FULL + !out_ready -> FULL, hold.
- Latency: an instruction accepted at edge N appears with out_valid=1 after edge N, i.e. 1 cycle.
- Operand capture on accept, for each of A and B:
  - addr==0 -> 0.
  - else wb_en & wb_addr==addr -> wb_data (bypass the same-edge Regs write).
  - else rdata.
- Stall refresh: while FULL and not draining, if wb_en & wb_addr!=0 & wb_addr==src_a, then op_a <= wb_data (likewise op_b/src_b). Held operands are never stale. Refresh is not applied on a draining cycle.
- dst:
  - opcode==0 (R-type) -> inst[15:11].
  - opcode 2 (j) -> 0.
  - opcode 3 (jal) -> 31.
  - else inst[20:16].
- imm:
  - opcode 0x0C/0x0D/0x0E (andi/ori/xori) -> zero-extend inst[15:0].
  - 0x0F (lui) -> {inst[15:0],16'h0}.
  - 0x02/0x03 -> {pc_in[31:28],inst[25:0],2'b00}.
  - else sign-extend inst[15:0].
- Output stability: registered outputs change only on accept, stall refresh or reset. They are held constant while out_valid=1 and out_ready=0, except the op_a/op_b refresh.
- in_valid=0 with junk inst: nothing is captured; R_addr_A/B still follow inst (harmless reads).

Test Plan:
- Reset, then Regs preloaded r5=0x00000005 and r6=0xFFFFFFFA; send add r7,r5,r6 (0x00A63820) with out_ready=1 -> next cycle out_valid=1, op_a=0x5, op_b=0xFFFFFFFA, dst=7, opcode=0, funct=0x20.
- Bypass: accept 0x00A63820 while wb_en=1, wb_addr=5, wb_data=0x1234 -> op_a=0x1234; same with wb_addr=0 and wb_data=0x1234 on an rs=0 instruction -> op_a=0.
- Stall refresh: hold out_ready=0 after the accept; pulse wb_en, wb_addr=6, wb_data=0xCAFEF00D -> op_b=0xCAFEF00D, in_ready=0, other outputs unchanged, out_valid stays 1.
- Immediates:
  - addi 0x2008FFFF -> imm=0xFFFFFFFF, dst=8.
  - ori 0x3508FFFF -> imm=0x0000FFFF.
  - lui 0x3C081234 -> imm=0x12340000.
  - jal 0x0C000004 with pc_in=0x40000000 -> imm=0x40000010, dst=31.
- Throughput: 32 instructions streamed with in_valid=1 and out_ready=1 -> 32 consecutive out_valid cycles, in order, no bubbles; random out_ready -> no loss or duplication.
- Reset mid-operation: FULL and stalled, assert rst=0 for one edge while in_valid=1 -> out_valid=0 and outputs 0; the instruction is not captured.

Source files
------------

// File: rtl/id_operand_fetch.sv
// Decode / operand-fetch stage: drives register-file read addresses, captures
// operands with write-back bypass and decoded fields into a one-entry output register.
module id_operand_fetch #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   inst,
  input  logic [DW-1:0] pc_in,
  output logic [AW-1:0] R_addr_A,
  output logic [AW-1:0] R_addr_B,
  input  logic [DW-1:0] rdata_A,
  input  logic [DW-1:0] rdata_B,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] op_a,
  output logic [DW-1:0] op_b,
  output logic [DW-1:0] imm,
  output logic [AW-1:0] dst,
  output logic [5:0]    opcode,
  output logic [5:0]    funct,
  output logic [AW-1:0] src_a,
  output logic [AW-1:0] src_b,
  output logic [DW-1:0] pc_out
);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t        state_r;
  state_t        state_nxt_s;
  logic          accept_s;
  logic          drain_s;
  logic          stall_s;
  logic [DW-1:0] op_a_r;
  logic [DW-1:0] op_b_r;
  logic [DW-1:0] imm_r;
  logic [AW-1:0] dst_r;
  logic [5:0]    opcode_r;
  logic [5:0]    funct_r;
  logic [AW-1:0] src_a_r;
  logic [AW-1:0] src_b_r;
  logic [DW-1:0] pc_r;
  logic [DW-1:0] fetch_a_s;
  logic [DW-1:0] fetch_b_s;
  logic [DW-1:0] imm_s;
  logic [AW-1:0] dst_s;

  // r0 reads as zero; a same-edge register-file write must be forwarded
  function automatic logic [DW-1:0] fetch_operand(
    input logic [AW-1:0] addr,
    input logic [DW-1:0] rdata,
    input logic          wen,
    input logic [AW-1:0] waddr,
    input logic [DW-1:0] wdata
  );
    logic [DW-1:0] val;
    if (addr == {AW{1'b0}}) begin
      val = {DW{1'b0}};
    end else if (wen && (waddr == addr)) begin
      val = wdata;
    end else begin
      val = rdata;
    end
    return val;
  endfunction

  function automatic logic [AW-1:0] decode_dst(input logic [31:0] iw);
    logic [AW-1:0] d;
    case (iw[31:26])
      6'h00:   d = iw[15:11];
      6'h02:   d = {AW{1'b0}};
      6'h03:   d = {AW{1'b1}};
      default: d = iw[20:16];
    endcase
    return d;
  endfunction

  function automatic logic [DW-1:0] decode_imm(input logic [31:0] iw, input logic [DW-1:0] pc);
    logic [DW-1:0] v;
    case (iw[31:26])
      6'h0C, 6'h0D, 6'h0E: v = {{(DW-16){1'b0}}, iw[15:0]};
      6'h0F:               v = {iw[15:0], {(DW-16){1'b0}}};
      6'h02, 6'h03:        v = {pc[DW-1:DW-4], iw[25:0], 2'b00};
      default:             v = {{(DW-16){iw[15]}}, iw[15:0]};
    endcase
    return v;
  endfunction

  assign R_addr_A  = inst[25:21];
  assign R_addr_B  = inst[20:16];
  assign out_valid = (state_r == ST_FULL);
  assign in_ready  = (state_r == ST_EMPTY) | out_ready;
  assign accept_s  = in_valid & in_ready;
  assign drain_s   = (state_r == ST_FULL) & out_ready;
  assign stall_s   = (state_r == ST_FULL) & ~out_ready;

  // Operand selection and field decode for the instruction being offered
  always_comb begin
    fetch_a_s = fetch_operand(inst[25:21], rdata_A, wb_en, wb_addr, wb_data);
    fetch_b_s = fetch_operand(inst[20:16], rdata_B, wb_en, wb_addr, wb_data);
    imm_s     = decode_imm(inst, pc_in);
    dst_s     = decode_dst(inst);
  end

  // Next-state logic for the one-entry output buffer
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_EMPTY: begin
        if (accept_s) begin
          state_nxt_s = ST_FULL;
        end else begin
          state_nxt_s = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (drain_s && !accept_s) begin
          state_nxt_s = ST_EMPTY;
        end else begin
          state_nxt_s = ST_FULL;
        end
      end
      default: state_nxt_s = ST_EMPTY;
    endcase
  end

  // State register and output payload; stalled operands track write-backs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r  <= ST_EMPTY;
      op_a_r   <= {DW{1'b0}};
      op_b_r   <= {DW{1'b0}};
      imm_r    <= {DW{1'b0}};
      dst_r    <= {AW{1'b0}};
      opcode_r <= 6'd0;
      funct_r  <= 6'd0;
      src_a_r  <= {AW{1'b0}};
      src_b_r  <= {AW{1'b0}};
      pc_r     <= {DW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (accept_s) begin
        op_a_r   <= fetch_a_s;
        op_b_r   <= fetch_b_s;
        imm_r    <= imm_s;
        dst_r    <= dst_s;
        opcode_r <= inst[31:26];
        funct_r  <= inst[5:0];
        src_a_r  <= inst[25:21];
        src_b_r  <= inst[20:16];
        pc_r     <= pc_in;
      end else if (stall_s) begin
        if (wb_en && (wb_addr != {AW{1'b0}}) && (wb_addr == src_a_r)) begin
          op_a_r <= wb_data;
        end
        if (wb_en && (wb_addr != {AW{1'b0}}) && (wb_addr == src_b_r)) begin
          op_b_r <= wb_data;
        end
      end
    end
  end

  assign op_a   = op_a_r;
  assign op_b   = op_b_r;
  assign imm    = imm_r;
  assign dst    = dst_r;
  assign opcode = opcode_r;
  assign funct  = funct_r;
  assign src_a  = src_a_r;
  assign src_b  = src_b_r;
  assign pc_out = pc_r;

endmodule

// File: tb/tb_id_operand_fetch.sv
// Directed bench for id_operand_fetch with a small behavioural register file.
module tb_id_operand_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] inst;
  logic [31:0] pc_in;
  logic [4:0]  R_addr_A, R_addr_B;
  logic [31:0] rdata_A, rdata_B;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] op_a, op_b, imm, pc_out;
  logic [4:0]  dst, src_a, src_b;
  logic [5:0]  opcode, funct;

  logic [31:0] regs [32];
  logic        tb_clear;
  int          total = 0;
  int          passed = 0;

  always #5 clk = ~clk;

  // Register file model: combinational read, write on clock edge
  always @(posedge clk) begin
    if (tb_clear) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else if (wb_en && wb_addr != 5'd0) begin
      regs[wb_addr] <= wb_data;
    end
  end
  assign rdata_A = (R_addr_A == 5'd0) ? 32'd0 : regs[R_addr_A];
  assign rdata_B = (R_addr_B == 5'd0) ? 32'd0 : regs[R_addr_B];

  id_operand_fetch #(.DW(32), .AW(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .inst(inst), .pc_in(pc_in), .R_addr_A(R_addr_A), .R_addr_B(R_addr_B),
    .rdata_A(rdata_A), .rdata_B(rdata_B), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready),
    .op_a(op_a), .op_b(op_b), .imm(imm), .dst(dst), .opcode(opcode),
    .funct(funct), .src_a(src_a), .src_b(src_b), .pc_out(pc_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; tb_clear = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    inst = 32'h00A63820; pc_in = 32'h0000_0040; wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
    tick();
    tb_clear = 1'b0; wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h0000_0005;
    tick();
    wb_addr = 5'd6; wb_data = 32'hFFFF_FFFA;
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %h exp 0", out_valid); else passed++;
    total++; if ({op_a, op_b, imm, pc_out} !== 128'd0) $display("FAIL reset_data got %h %h %h %h exp 0", op_a, op_b, imm, pc_out); else passed++;
    total++; if ({dst, opcode, funct, src_a, src_b} !== 27'd0) $display("FAIL reset_fields got %h exp 0", {dst, opcode, funct, src_a, src_b}); else passed++;
    rst = 1'b1; wb_en = 1'b0; in_valid = 1'b0;
    tick();
    total++; if (in_ready !== 1'b1) $display("FAIL post_reset_ready got %h exp 1", in_ready); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL post_reset_valid got %h exp 0", out_valid); else passed++;
  endtask

  task automatic test_basic();
    in_valid = 1'b1; out_ready = 1'b1; inst = 32'h00A63820; pc_in = 32'h0000_0100;
    #1;
    total++; if (R_addr_A !== 5'd5 || R_addr_B !== 5'd6) $display("FAIL raddr got %0d %0d exp 5 6", R_addr_A, R_addr_B); else passed++;
    tick();
    total++; if (out_valid !== 1'b1) $display("FAIL basic_valid got %h exp 1", out_valid); else passed++;
    total++; if (op_a !== 32'h5 || op_b !== 32'hFFFF_FFFA) $display("FAIL basic_ops got %h %h exp 5 fffffffa", op_a, op_b); else passed++;
    total++; if (dst !== 5'd7 || opcode !== 6'd0 || funct !== 6'h20) $display("FAIL basic_fields got %0d %h %h exp 7 0 20", dst, opcode, funct); else passed++;
    total++; if (src_a !== 5'd5 || src_b !== 5'd6 || pc_out !== 32'h100) $display("FAIL basic_src got %0d %0d %h exp 5 6 100", src_a, src_b, pc_out); else passed++;
    in_valid = 1'b0; inst = 32'hFFFF_FFFF;
    #1;
    total++; if (R_addr_A !== 5'd31) $display("FAIL junk_raddr got %0d exp 31", R_addr_A); else passed++;
    tick();
    total++; if (out_valid !== 1'b0 || op_a !== 32'h5) $display("FAIL junk_nocapture got %h %h exp 0 5", out_valid, op_a); else passed++;
  endtask

  task automatic test_bypass();
    in_valid = 1'b1; out_ready = 1'b1; inst = 32'h00A63820;
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h0000_1234;
    tick();
    total++; if (op_a !== 32'h1234 || op_b !== 32'hFFFF_FFFA) $display("FAIL bypass_a got %h %h exp 1234 fffffffa", op_a, op_b); else passed++;
    inst = 32'h00063820; wb_addr = 5'd0;
    tick();
    total++; if (op_a !== 32'h0 || src_a !== 5'd0) $display("FAIL bypass_r0 got %h %0d exp 0 0", op_a, src_a); else passed++;
    inst = 32'h00A63820; wb_addr = 5'd6; wb_data = 32'h5555_AAAA;
    tick();
    total++; if (op_a !== 32'h1234 || op_b !== 32'h5555_AAAA) $display("FAIL bypass_b got %h %h exp 1234 5555aaaa", op_a, op_b); else passed++;
    in_valid = 1'b0; wb_en = 1'b0;
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL bypass_drain got %h exp 0", out_valid); else passed++;
  endtask

  task automatic test_stall_refresh();
    in_valid = 1'b1; out_ready = 1'b0; inst = 32'h00A63820; pc_in = 32'h0000_0200;
    tick();
    total++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || op_b !== 32'h5555_AAAA) $display("FAIL stall_accept got %h %h %h exp 1 0 5555aaaa", out_valid, in_ready, op_b); else passed++;
    inst = 32'h2008FFFF; wb_en = 1'b1; wb_addr = 5'd6; wb_data = 32'hCAFE_F00D;
    tick();
    total++; if (op_b !== 32'hCAFE_F00D) $display("FAIL stall_refresh got %h exp cafef00d", op_b); else passed++;
    total++; if (out_valid !== 1'b1 || in_ready !== 1'b0) $display("FAIL stall_hold got %h %h exp 1 0", out_valid, in_ready); else passed++;
    total++; if (op_a !== 32'h1234 || imm !== 32'h3820 || dst !== 5'd7 || pc_out !== 32'h200) $display("FAIL stall_stable got %h %h %0d %h exp 1234 3820 7 200", op_a, imm, dst, pc_out); else passed++;
    in_valid = 1'b0; out_ready = 1'b1; wb_data = 32'h1111_1111;
    tick();
    total++; if (out_valid !== 1'b0 || op_b !== 32'hCAFE_F00D) $display("FAIL drain_norefresh got %h %h exp 0 cafef00d", out_valid, op_b); else passed++;
    wb_en = 1'b0;
  endtask

  task automatic test_immediates();
    logic [31:0] t_inst [6];
    logic [31:0] t_pc   [6];
    logic [31:0] t_imm  [6];
    logic [4:0]  t_dst  [6];
    t_inst[0] = 32'h2008FFFF; t_pc[0] = 32'h0;         t_imm[0] = 32'hFFFF_FFFF; t_dst[0] = 5'd8;
    t_inst[1] = 32'h3508FFFF; t_pc[1] = 32'h0;         t_imm[1] = 32'h0000_FFFF; t_dst[1] = 5'd8;
    t_inst[2] = 32'h3C081234; t_pc[2] = 32'h0;         t_imm[2] = 32'h1234_0000; t_dst[2] = 5'd8;
    t_inst[3] = 32'h0C000004; t_pc[3] = 32'h4000_0000; t_imm[3] = 32'h4000_0010; t_dst[3] = 5'd31;
    t_inst[4] = 32'h08000004; t_pc[4] = 32'hF000_0000; t_imm[4] = 32'hF000_0010; t_dst[4] = 5'd0;
    t_inst[5] = 32'h11090005; t_pc[5] = 32'h0;         t_imm[5] = 32'h0000_0005; t_dst[5] = 5'd9;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; inst = t_inst[i]; pc_in = t_pc[i];
      tick();
      total++; if (imm !== t_imm[i] || dst !== t_dst[i]) $display("FAIL imm_%0d got %h %0d exp %h %0d", i, imm, dst, t_imm[i], t_dst[i]); else passed++;
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      in_valid = 1'b1; inst = {6'h08, 5'd0, 5'(i), 16'(i)}; pc_in = 32'(i * 4);
      tick();
      total++; if (out_valid !== 1'b1 || pc_out !== 32'(i * 4) || imm !== 32'(i)) $display("FAIL b2b_%0d got %h %h %h exp 1 %h %h", i, out_valid, pc_out, imm, 32'(i * 4), 32'(i)); else passed++;
    end
    in_valid = 1'b0;
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL b2b_end got %h exp 0", out_valid); else passed++;
  endtask

  task automatic test_random_ready();
    int sent = 0, recv = 0, cycles = 0;
    logic m_full = 1'b0;
    logic rdy_m, acc_m, drn_m;
    while (recv < 20 && cycles < 400) begin
      out_ready = 1'($urandom_range(0, 1));
      in_valid = (sent < 20);
      inst = 32'h2000_0000 | 32'(sent); pc_in = 32'h1000 + 32'(sent * 4);
      #1;
      rdy_m = !m_full | out_ready;
      acc_m = in_valid & rdy_m;
      drn_m = m_full & out_ready;
      total++; if (in_ready !== rdy_m || out_valid !== m_full) $display("FAIL rnd_hs_%0d got %h %h exp %h %h", cycles, in_ready, out_valid, rdy_m, m_full); else passed++;
      if (drn_m) begin
        total++; if (pc_out !== 32'h1000 + 32'(recv * 4)) $display("FAIL rnd_order_%0d got %h exp %h", recv, pc_out, 32'h1000 + 32'(recv * 4)); else passed++;
        recv++;
      end
      tick();
      if (acc_m) sent++;
      m_full = acc_m | (m_full & !drn_m);
      cycles++;
    end
    total++; if (recv !== 20) $display("FAIL rnd_count got %0d exp 20", recv); else passed++;
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; out_ready = 1'b0; inst = 32'h00A63820; pc_in = 32'h0000_0300;
    tick();
    total++; if (out_valid !== 1'b1) $display("FAIL mid_full got %h exp 1", out_valid); else passed++;
    rst = 1'b0; inst = 32'h3C08BEEF; pc_in = 32'h0000_0304;
    tick();
    total++; if (out_valid !== 1'b0 || op_a !== 32'd0 || op_b !== 32'd0) $display("FAIL mid_reset got %h %h %h exp 0 0 0", out_valid, op_a, op_b); else passed++;
    total++; if (imm !== 32'd0 || pc_out !== 32'd0 || dst !== 5'd0) $display("FAIL mid_reset_fields got %h %h %0d exp 0 0 0", imm, pc_out, dst); else passed++;
    rst = 1'b1; in_valid = 1'b0;
    tick();
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL mid_nocapture got %h %h exp 0 1", out_valid, in_ready); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bypass();
    test_stall_refresh();
    test_immediates();
    test_back_to_back();
    test_random_ready();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
